// File: rtl/linear_loader.sv
// linear_loader: serial-stream front end for the linear layer.
// Assembles activation matrix, weight matrix and bias vector from a
// valid/ready element stream, pulses start, then holds the arrays until
// the layer reports done. Weights/bias may be retained across frames.
// Array elements are signed two's complement, DATA_SIZE bits each.
module linear_loader #(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_SIZE   = 8
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic [DATA_SIZE-1:0]                                    in_data,
  input  logic                                                    wt_keep,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0]  mat_a,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0]  wt,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]                   bias,
  output logic                                                    start,
  input  logic                                                    done,
  output logic                                                    busy,
  output logic                                                    frame_done
);

  localparam int IDX_W = $clog2(MATRIX_SIZE);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MATRIX_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_W,
    LOAD_B,
    START,
    WAIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic             keep_r;

  logic             loading;
  logic             xfer;
  logic             col_last;
  logic             row_last;
  logic             phase_end;

  // Transfer qualification is decoded from registered state, so in_ready
  // never depends on in_valid.
  assign loading   = (state == LOAD_A) || (state == LOAD_W) || (state == LOAD_B);
  assign xfer      = in_valid && loading;
  assign col_last  = (col == LAST);
  assign row_last  = (row == LAST);
  // Bias phase is a single row, so only the column count ends it.
  assign phase_end = xfer && col_last && ((state == LOAD_B) || row_last);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and decoded control outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start     = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (in_valid) begin
          state_nxt = LOAD_A;
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (phase_end) begin
          state_nxt = keep_r ? START : LOAD_W;
        end
      end
      LOAD_W: begin
        in_ready = 1'b1;
        if (phase_end) begin
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (phase_end) begin
          state_nxt = START;
        end
      end
      START: begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Completion pulse: registered on the edge that leaves WAIT, so it is
  // visible in the first IDLE cycle together with busy falling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == WAIT) && done;
    end
  end

  // Weight-retention flag, captured only as a frame begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keep_r <= 1'b0;
    end else if ((state == IDLE) && in_valid) begin
      keep_r <= wt_keep;
    end
  end

  // Row-major element position; cleared at every phase boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (xfer) begin
      if (phase_end) begin
        row <= '0;
        col <= '0;
      end else if (col_last) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Array storage: written only on accepted transfers, hence stable
  // throughout START and WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mat_a <= '0;
      wt    <= '0;
      bias  <= '0;
    end else if (xfer) begin
      case (state)
        LOAD_A:  mat_a[row][col] <= in_data;
        LOAD_W:  wt[row][col]    <= in_data;
        LOAD_B:  bias[col]       <= in_data;
        default: ;
      endcase
    end
  end

  // Control sanity: start is a single-cycle pulse and never coincides
  // with accepting stream data.
  a_start_pulse : assert property (@(posedge clk) disable iff (!reset)
    start |=> !start);
  a_start_no_ready : assert property (@(posedge clk) disable iff (!reset)
    start |-> !in_ready);

endmodule

// File: tb/tb_linear_loader.sv
// Bench for linear_loader (N=2, 8-bit elements): directed frames from the
// test plan plus randomized frames, checked each cycle against a
// frame-position model and pinned by literal array expectations.
module tb_linear_loader;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int NN = N * N;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [DW-1:0]                in_data = '0;
  logic                         wt_keep = 1'b0;
  logic [N-1:0][N-1:0][DW-1:0]  mat_a;
  logic [N-1:0][N-1:0][DW-1:0]  wt;
  logic [N-1:0][DW-1:0]         bias;
  logic                         start;
  logic                         done = 1'b0;
  logic                         busy;
  logic                         frame_done;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  logic [DW-1:0] stream[$];
  logic [DW-1:0] lit_a[NN];
  logic [DW-1:0] lit_w[NN];
  logic [DW-1:0] lit_b[N];

  always #5 clk = ~clk;

  linear_loader #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wt_keep    (wt_keep),
    .mat_a      (mat_a),
    .wt         (wt),
    .bias       (bias),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a frame is a count of consumed elements; the destination of an
  // element follows from its position in the stream.
  // m_mode: 0 idle, 1 accepting, 2 start cycle, 3 waiting for done.
  logic [DW-1:0] m_a[N][N];
  logic [DW-1:0] m_w[N][N];
  logic [DW-1:0] m_b[N];
  int            m_mode = 0;
  int            m_pos  = 0;
  int            m_need = 0;
  bit            m_fd   = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0;
      m_pos  = 0;
      m_need = 0;
      m_fd   = 1'b0;
      for (int r = 0; r < N; r++) begin
        m_b[r] = '0;
        for (int c = 0; c < N; c++) begin
          m_a[r][c] = '0;
          m_w[r][c] = '0;
        end
      end
    end else begin
      m_fd = 1'b0;
      case (m_mode)
        0: if (in_valid) begin
          m_pos  = 0;
          m_need = wt_keep ? NN : 2 * NN + N;
          m_mode = 1;
        end
        1: if (in_valid) begin
          if (m_pos < NN)          m_a[m_pos / N][m_pos % N] = in_data;
          else if (m_pos < 2 * NN) m_w[(m_pos - NN) / N][(m_pos - NN) % N] = in_data;
          else                     m_b[m_pos - 2 * NN] = in_data;
          m_pos++;
          if (m_pos == m_need) m_mode = 2;
        end
        2: m_mode = 3;
        default: if (done) begin
          m_mode = 0;
          m_fd   = 1'b1;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, m_mode == 1);
      chk("start", start, m_mode == 2);
      chk("busy", busy, m_mode != 0);
      chk("frame_done", frame_done, m_fd);
      for (int r = 0; r < N; r++) begin
        chk($sformatf("bias[%0d]", r), bias[r], m_b[r]);
        for (int c = 0; c < N; c++) begin
          chk($sformatf("mat_a[%0d][%0d]", r, c), mat_a[r][c], m_a[r][c]);
          chk($sformatf("wt[%0d][%0d]", r, c), wt[r][c], m_w[r][c]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Literal expectations checked against both the DUT and the model.
  task automatic lit_check(input string tag);
    for (int r = 0; r < N; r++) begin
      chk({tag, "_bias"}, bias[r], lit_b[r]);
      chk({tag, "_model_bias"}, m_b[r], lit_b[r]);
      for (int c = 0; c < N; c++) begin
        chk({tag, "_mat_a"}, mat_a[r][c], lit_a[r * N + c]);
        chk({tag, "_model_mat_a"}, m_a[r][c], lit_a[r * N + c]);
        chk({tag, "_wt"}, wt[r][c], lit_w[r * N + c]);
        chk({tag, "_model_wt"}, m_w[r][c], lit_w[r * N + c]);
      end
    end
  endtask

  // Push the first n stream elements; mode 0 continuous, 1 pattern 1,0,0,
  // otherwise random valid. wt_keep is scrambled once the frame is running.
  task automatic feed(input int n, input bit keep, input int mode);
    int idx;
    int guard;
    bit v;
    bit acc;
    idx   = 0;
    guard = 0;
    wt_keep = keep;
    while (idx < n && guard < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? stream[idx] : DW'($urandom);
      acc      = v && in_ready;
      tick();
      if (acc) idx++;
      if (busy) wt_keep = 1'($urandom_range(0, 1));
      guard++;
    end
    in_valid = 1'b0;
    chk("feed_count", idx, n);
  endtask

  // Wait for start, then answer with done after dly cycles.
  task automatic finish_frame(input int dly, input bit hold);
    int cnt;
    cnt = 0;
    while (!start && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("start_seen", start, 1);
    tick();
    chk("start_width", start, 0);
    repeat (dly) tick();
    done = 1'b1;
    cnt  = 0;
    tick();
    if (!hold) done = 1'b0;
    while (!frame_done && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("frame_done_seen", frame_done, 1);
    chk("busy_after_done", busy, 0);
    tick();
    chk("frame_done_width", frame_done, 0);
    done = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    armed = 1'b1;

    // Reset state.
    lit_a = '{default: '0};
    lit_w = '{default: '0};
    lit_b = '{default: '0};
    lit_check("reset");
    chk("reset_in_ready", in_ready, 0);
    chk("reset_start", start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    reset = 1'b1;
    tick();

    // Full frame, continuous valid.
    stream = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'hFF, 8'hFE};
    feed(10, 1'b0, 0);
    chk("full_start_after_last", start, 1);
    tick();
    chk("full_start_once", start, 0);
    chk("full_busy_wait", busy, 1);
    repeat (4) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("full_frame_done", frame_done, 1);
    chk("full_busy_fall", busy, 0);
    tick();
    chk("full_frame_done_once", frame_done, 0);
    lit_a = '{8'd1, 8'd2, 8'd3, 8'd4};
    lit_w = '{8'd5, 8'd6, 8'd7, 8'd8};
    lit_b = '{8'hFF, 8'hFE};
    lit_check("full");

    // Same frame with stalls.
    feed(10, 1'b0, 1);
    finish_frame(3, 1'b0);
    lit_check("stalled");

    // Weight reuse.
    stream = '{8'd9, 8'd10, 8'd11, 8'd12};
    feed(4, 1'b1, 0);
    chk("reuse_start_after_4", start, 1);
    finish_frame(2, 1'b0);
    lit_a = '{8'd9, 8'd10, 8'd11, 8'd12};
    lit_check("reuse");

    // Reset during weight loading clears everything including weights.
    stream = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26};
    feed(6, 1'b0, 0);
    chk("midw_busy", busy, 1);
    chk("midw_in_ready", in_ready, 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    lit_a = '{default: '0};
    lit_w = '{default: '0};
    lit_b = '{default: '0};
    lit_check("rst");
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    stream = '{8'd31, 8'd32, 8'd33, 8'd34};
    feed(4, 1'b1, 0);
    finish_frame(1, 1'b0);
    lit_a = '{8'd31, 8'd32, 8'd33, 8'd34};
    lit_check("keep_after_rst");

    // done held high through START and WAIT.
    stream = '{8'hF0, 8'h0F, 8'h80, 8'h7F, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    done = 1'b1;
    feed(10, 1'b0, 0);
    chk("held_start", start, 1);
    tick();
    chk("held_start_ignores_done", busy, 1);
    chk("held_no_fd_in_start", frame_done, 0);
    tick();
    chk("held_frame_done", frame_done, 1);
    chk("held_busy_fall", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_no_restart", start, 0);
      chk("held_idle", busy, 0);
      chk("held_single_fd", frame_done, 0);
    end
    done = 1'b0;
    lit_a = '{8'hF0, 8'h0F, 8'h80, 8'h7F};
    lit_w = '{8'd1, 8'd2, 8'd3, 8'd4};
    lit_b = '{8'd5, 8'd6};
    lit_check("held");

    // Randomized frames, including back-to-back starts.
    for (int f = 0; f < 30; f++) begin
      bit keep;
      int n;
      keep = 1'($urandom_range(0, 1));
      n    = keep ? NN : 2 * NN + N;
      stream.delete();
      for (int i = 0; i < n; i++) stream.push_back(DW'($urandom));
      feed(n, keep, int'($urandom_range(0, 2)));
      finish_frame(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
